// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready handshakes on both sides and a full flag set.
// The multiply op runs as an iterative shift-add over WIDTH cycles.
`timescale 1ns/1ps

module alu_seq_hs #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             oCarry,
    output logic             oZero,
    output logic             oNeg,
    output logic             oOvf
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             is_mul;
    logic             mul_last;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]   step_sum;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign is_mul   = (ctrl == OP_MUL) && (MUL_EN != 0);
    assign mul_last = (cnt == CW'(WIDTH - 1));

    // Single-cycle ops, evaluated straight from the handshake inputs on accept.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                sum_ext = {1'b0, data1} + {1'b0, data2};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (data1[MSB] == data2[MSB]) && (alu_res[MSB] != data1[MSB]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, data1} - {1'b0, data2};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (data1[MSB] != data2[MSB]) && (alu_res[MSB] != data1[MSB]);
            end
            OP_AND:  alu_res = data1 & data2;
            OP_OR:   alu_res = data1 | data2;
            OP_XOR:  alu_res = data1 ^ data2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_PASS: alu_res = data1;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: the multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt  = {step_sum, acc[WIDTH-1:1]};
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (mul_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the multiply operands/accumulator are always loaded on accept before use,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && is_mul) begin
            mcand <= data1;
            acc   <= {{WIDTH{1'b0}}, data2};
            cnt   <= '0;
        end else if (state == MUL) begin
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            oCarry <= 1'b0;
            oZero  <= 1'b0;
            oNeg   <= 1'b0;
            oOvf   <= 1'b0;
        end else if (state == IDLE && in_valid && !is_mul) begin
            out    <= alu_res;
            oCarry <= alu_c;
            oZero  <= (alu_res == '0);
            oNeg   <= alu_res[MSB];
            oOvf   <= alu_v;
        end else if (state == MUL && mul_last) begin
            out    <= acc_nxt[WIDTH-1:0];
            oCarry <= |acc_nxt[2*WIDTH-1:WIDTH];
            oZero  <= (acc_nxt[WIDTH-1:0] == '0);
            oNeg   <= acc_nxt[MSB];
            oOvf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs: an arithmetic reference model with a scoreboard
// checked every cycle, plus directed vectors with hand-computed results.
`timescale 1ns/1ps

module tb_alu_seq_hs;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ctrl;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         oCarry, oZero, oNeg, oOvf;

    alu_seq_hs #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .oCarry    (oCarry),
        .oZero     (oZero),
        .oNeg      (oNeg),
        .oOvf      (oOvf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;     // {carry, zero, neg, ovf}
        int           vcyc;
    } exp_t;

    // Reference: plain arithmetic on wide/signed integers.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] wide;
        longint      sa, sb, sr;
        logic        c, v;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        c    = 1'b0;
        v    = 1'b0;
        wide = '0;
        case (op)
            3'b010: begin
                wide = {32'b0, a} + {32'b0, b};
                c    = wide[32];
                sr   = sa + sb;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b110: begin
                wide = {32'b0, a} - {32'b0, b};
                c    = (a < b);
                sr   = sa - sb;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b000: wide = {32'b0, a & b};
            3'b001: wide = {32'b0, a | b};
            3'b111: wide = {32'b0, a ^ b};
            3'b011: wide = (sa < sb) ? 64'd1 : 64'd0;
            3'b100: begin
                wide = {32'b0, a} * {32'b0, b};
                c    = (wide[63:32] != 32'b0);
            end
            default: wide = {32'b0, a};
        endcase
        e.res  = wide[W-1:0];
        e.fl   = {c, (wide[W-1:0] == '0), wide[W-1], v};
        e.vcyc = 0;
        return e;
    endfunction

    // Scoreboard compare, sampled on the falling edge.
    exp_t q[$];
    exp_t e_new;
    bit   started    = 0;
    bit   just_reset = 0;
    bit   exp_valid;
    bit   was_empty;

    always @(negedge clk) begin
        if (!started) begin
            if (rst === 1'b1) begin
                started    = 1;
                just_reset = 1;
            end
        end else begin
            exp_valid = (q.size() != 0) && (cyc >= q[0].vcyc);
            if (just_reset) begin
                check("rst_out", out, 0);
                check("rst_flags", {oCarry, oZero, oNeg, oOvf}, 0);
            end
            check("out_valid", out_valid, exp_valid);
            check("in_ready", in_ready, q.size() == 0);
            if (exp_valid) begin
                check("sb_out", out, q[0].res);
                check("sb_flags", {oCarry, oZero, oNeg, oOvf}, q[0].fl);
            end
            if (rst) begin
                q.delete();
                just_reset = 1;
            end else begin
                just_reset = 0;
                was_empty  = (q.size() == 0);
                if (exp_valid && out_ready) void'(q.pop_front());
                if (was_empty && in_valid) begin
                    e_new      = model(ctrl, data1, data2);
                    e_new.vcyc = cyc + ((ctrl == 3'b100) ? W + 1 : 1);
                    q.push_back(e_new);
                end
            end
        end
    end

    // Issue one op, check the hand-computed result and latency, then hand it off
    // after holding out_ready low for `hold` cycles with a competing in_valid.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eo, input logic [3:0] ef, input int el, input int hold,
                          input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        ctrl     = op;
        data1    = a;
        data2    = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ctrl     = 3'($urandom);
        data1    = $urandom;
        data2    = $urandom;
        n = 1;
        while (!out_valid && n < 200) begin
            out_ready = n[0];
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        check({name, "_lat"}, n, el);
        check({name, "_out"}, out, eo);
        check({name, "_flags"}, {oCarry, oZero, oNeg, oOvf}, ef);
        repeat (hold) begin
            in_valid = 1'b1;
            ctrl     = 3'b010;
            data1    = $urandom;
            data2    = $urandom;
            @(posedge clk); #1;
            check({name, "_hold_out"}, out, eo);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, "_idle_ready"}, in_ready, 1);
        check({name, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        ctrl      = 3'b010;
        data1     = 32'h1234_5678;
        data2     = 32'h1111_1111;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_out", out, 0);
        @(posedge clk); #1;

        // flags order {carry, zero, neg, ovf}
        run_op(3'b010, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100, 1, 0, "add_wrap");
        run_op(3'b010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0011, 1, 0, "add_ovf");
        run_op(3'b110, 32'd5,         32'd5,         32'h0,         4'b0100, 1, 0, "sub_eq");
        run_op(3'b110, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1010, 1, 0, "sub_borrow");
        run_op(3'b110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0001, 1, 0, "sub_ovf");
        run_op(3'b011, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1, 0, "slt_true");
        run_op(3'b011, 32'h1,         32'hFFFF_FFFF, 32'h0,         4'b0100, 1, 0, "slt_false");
        run_op(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1, 0, "and");
        run_op(3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000, 1, 0, "or");
        run_op(3'b111, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 4'b0000, 1, 0, "xor");
        run_op(3'b111, 32'h1234_5678, 32'h1234_5678, 32'h0,         4'b0100, 1, 0, "xor_self");
        run_op(3'b101, 32'h8000_0001, 32'hDEAD_BEEF, 32'h8000_0001, 4'b0010, 1, 0, "pass");
        run_op(3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0,         4'b1100, W + 1, 0, "mul_hi");
        run_op(3'b100, 32'd7,         32'd6,         32'd42,        4'b0000, W + 1, 0, "mul_small");
        run_op(3'b100, 32'h0,         32'hFFFF_FFFF, 32'h0,         4'b0100, W + 1, 0, "mul_zero");
        run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         4'b1000, W + 1, 0, "mul_max");

        // result held with out_ready low while a new op knocks
        run_op(3'b010, 32'd100,       32'd23,        32'd123,       4'b0000, 1, 10, "hold_add");
        run_op(3'b100, 32'd9,         32'd9,         32'd81,        4'b0000, W + 1, 10, "hold_mul");

        // reset in the tenth cycle of a multiply
        in_valid = 1'b1;
        ctrl     = 3'b100;
        data1    = 32'd3;
        data2    = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midmul_rst_valid", out_valid, 0);
        check("midmul_rst_ready", in_ready, 1);
        check("midmul_rst_out", out, 0);
        repeat (W + 4) begin
            @(posedge clk); #1;
        end
        check("midmul_no_result", out_valid, 0);
        run_op(3'b010, 32'd2, 32'd2, 32'd4, 4'b0000, 1, 0, "add_after_rst");

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
